// File: rtl/frame_sched_pkg.sv
// ---------------------------------------------------------------------------
// frame_sched_pkg
// Shared types and constants for the triple-buffer frame scheduler.
//   slot_t         : 2-bit image slot index (0..2)
//   sched_state_t  : scheduler FSM states IDLE / FILL / STREAM
//   W0 / P0 / R0   : slot assignment after reset or while disabled
//   IMAGE_SIZE_DEFAULT : pixels per slot (80*48)
// ---------------------------------------------------------------------------
package frame_sched_pkg;

    typedef logic [1:0] slot_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } sched_state_t;

    localparam slot_t W0 = 2'd0;
    localparam slot_t P0 = 2'd1;
    localparam slot_t R0 = 2'd2;

    localparam int IMAGE_SIZE_DEFAULT = 3840;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up counter that sticks at all-ones instead of wrapping.
//   rgb_clk : clock
//   nrst    : asynchronous active-low reset, clears the count
//   inc     : add one this cycle (ignored once saturated)
//   count   : current value
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             rgb_clk,
    input  logic             nrst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge rgb_clk or negedge nrst) begin
        if (!nrst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/frame_scheduler.sv
// ---------------------------------------------------------------------------
// frame_scheduler
// Triple-buffer slot manager for the pixel frame RAM. Three slots rotate
// between writer (W), pending/latest-complete (P) and reader (R); writer and
// reader never share a slot. All outputs are registered.
//
// Ports:
//   rgb_clk        : sole clock
//   nrst           : asynchronous active-low reset
//   enable         : scheduler runs only while high
//   wr_frame_done  : writer finished an image in wr_slot (one event per cycle)
//   rd_frame_req   : reader starts a new image (one event per cycle)
//   wr_slot/rd_slot: slots owned by writer / reader
//   wr_base/rd_base: slot * IMAGE_SIZE
//   rd_frame_new   : 1-cycle flag after an accepted request; 1 = new image
//   stream_ready   : high while at least one complete image exists
//   dropped_cnt    : completed images overwritten before being read
//   repeat_cnt     : read requests served with a stale image
//
// Build option: define FRAME_SCHED_STATS_EN to implement the two saturating
// statistics counters; otherwise both outputs are tied to zero.
// ---------------------------------------------------------------------------
module frame_scheduler
    import frame_sched_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 32,
    parameter int IMAGE_SIZE     = IMAGE_SIZE_DEFAULT,
    parameter int STAT_WIDTH     = 16
) (
    input  logic                      rgb_clk,
    input  logic                      nrst,
    input  logic                      enable,
    input  logic                      wr_frame_done,
    input  logic                      rd_frame_req,
    output logic [1:0]                wr_slot,
    output logic [1:0]                rd_slot,
    output logic [RAM_ADDR_WIDTH-1:0] wr_base,
    output logic [RAM_ADDR_WIDTH-1:0] rd_base,
    output logic                      rd_frame_new,
    output logic                      stream_ready,
    output logic [STAT_WIDTH-1:0]     dropped_cnt,
    output logic [STAT_WIDTH-1:0]     repeat_cnt
);

    localparam logic [RAM_ADDR_WIDTH-1:0] BASE1 = RAM_ADDR_WIDTH'(IMAGE_SIZE);
    localparam logic [RAM_ADDR_WIDTH-1:0] BASE2 = RAM_ADDR_WIDTH'(2 * IMAGE_SIZE);

    // Constant-only slot-to-address mux; slot 3 never occurs.
    function automatic logic [RAM_ADDR_WIDTH-1:0] base_of(input slot_t s);
        case (s)
            2'd1:    base_of = BASE1;
            2'd2:    base_of = BASE2;
            default: base_of = '0;
        endcase
    endfunction

    sched_state_t state_reg, state_next;
    slot_t        w_slot_reg, w_slot_next;
    slot_t        p_slot_reg, p_slot_next;
    slot_t        r_slot_reg, r_slot_next;
    logic         fresh_reg, fresh_next;
    logic         rd_frame_new_reg, rd_frame_new_next;
    logic         stream_ready_reg;
    logic [RAM_ADDR_WIDTH-1:0] wr_base_reg, rd_base_reg;

    // State and datapath registers
    always_ff @(posedge rgb_clk or negedge nrst) begin
        if (!nrst) begin
            state_reg        <= IDLE;
            w_slot_reg       <= W0;
            p_slot_reg       <= P0;
            r_slot_reg       <= R0;
            fresh_reg        <= 1'b0;
            rd_frame_new_reg <= 1'b0;
            stream_ready_reg <= 1'b0;
            wr_base_reg      <= base_of(W0);
            rd_base_reg      <= base_of(R0);
        end else begin
            state_reg        <= state_next;
            w_slot_reg       <= w_slot_next;
            p_slot_reg       <= p_slot_next;
            r_slot_reg       <= r_slot_next;
            fresh_reg        <= fresh_next;
            rd_frame_new_reg <= rd_frame_new_next;
            stream_ready_reg <= (state_next == STREAM);
            wr_base_reg      <= base_of(w_slot_next);
            rd_base_reg      <= base_of(r_slot_next);
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    state_next = FILL;
                FILL:    if (wr_frame_done) state_next = STREAM;
                STREAM:  state_next = STREAM;
                default: state_next = IDLE;
            endcase
        end
    end

    // Slot rotation. In STREAM a same-cycle done+request is resolved as the
    // done swap followed by the request swap, so the request always sees a
    // fresh image and the reader gets the one just completed.
    always_comb begin
        w_slot_next       = w_slot_reg;
        p_slot_next       = p_slot_reg;
        r_slot_next       = r_slot_reg;
        fresh_next        = fresh_reg;
        rd_frame_new_next = 1'b0;
        if (!enable) begin
            w_slot_next = W0;
            p_slot_next = P0;
            r_slot_next = R0;
            fresh_next  = 1'b0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (wr_frame_done) begin
                        w_slot_next = p_slot_reg;
                        p_slot_next = w_slot_reg;
                        fresh_next  = 1'b1;
                    end
                end
                STREAM: begin
                    if (wr_frame_done) begin
                        w_slot_next = p_slot_reg;
                        p_slot_next = w_slot_reg;
                        fresh_next  = 1'b1;
                    end
                    if (rd_frame_req && fresh_next) begin
                        r_slot_next       = p_slot_next;
                        p_slot_next       = r_slot_reg;
                        fresh_next        = 1'b0;
                        rd_frame_new_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_slot      = w_slot_reg;
    assign rd_slot      = r_slot_reg;
    assign wr_base      = wr_base_reg;
    assign rd_base      = rd_base_reg;
    assign rd_frame_new = rd_frame_new_reg;
    assign stream_ready = stream_ready_reg;

`ifdef FRAME_SCHED_STATS_EN
    logic drop_inc;
    logic repeat_inc;

    // A done while P is still unread overwrites that image. A lone request
    // with nothing fresh re-serves the reader's current image.
    assign drop_inc   = enable && (state_reg == STREAM) && wr_frame_done && fresh_reg;
    assign repeat_inc = enable && (state_reg == STREAM) && rd_frame_req &&
                        !wr_frame_done && !fresh_reg;

    sat_counter #(.WIDTH(STAT_WIDTH)) u_dropped_cnt (
        .rgb_clk (rgb_clk),
        .nrst    (nrst),
        .inc     (drop_inc),
        .count   (dropped_cnt)
    );

    sat_counter #(.WIDTH(STAT_WIDTH)) u_repeat_cnt (
        .rgb_clk (rgb_clk),
        .nrst    (nrst),
        .inc     (repeat_inc),
        .count   (repeat_cnt)
    );
`else
    assign dropped_cnt = '0;
    assign repeat_cnt  = '0;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_frame_scheduler
// Directed self-checking bench for frame_scheduler (IMAGE_SIZE = 3840).
// Counter expectations follow whether FRAME_SCHED_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_frame_scheduler;

`ifdef FRAME_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        rgb_clk;
    logic        nrst;
    logic        enable;
    logic        wr_frame_done;
    logic        rd_frame_req;
    logic [1:0]  wr_slot;
    logic [1:0]  rd_slot;
    logic [31:0] wr_base;
    logic [31:0] rd_base;
    logic        rd_frame_new;
    logic        stream_ready;
    logic [15:0] dropped_cnt;
    logic [15:0] repeat_cnt;

    int n_checks;
    int n_pass;
    int n_fail;

    frame_scheduler dut (
        .rgb_clk       (rgb_clk),
        .nrst          (nrst),
        .enable        (enable),
        .wr_frame_done (wr_frame_done),
        .rd_frame_req  (rd_frame_req),
        .wr_slot       (wr_slot),
        .rd_slot       (rd_slot),
        .wr_base       (wr_base),
        .rd_base       (rd_base),
        .rd_frame_new  (rd_frame_new),
        .stream_ready  (stream_ready),
        .dropped_cnt   (dropped_cnt),
        .repeat_cnt    (repeat_cnt)
    );

    initial rgb_clk = 1'b0;
    always #5 rgb_clk = ~rgb_clk;

    function automatic logic [31:0] cnt(input int n);
        cnt = STATS ? 32'(n) : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of pulses, then sample #1 after the edge.
    task automatic step(input logic done, input logic req);
        wr_frame_done = done;
        rd_frame_req  = req;
        @(posedge rgb_clk);
        #1;
        wr_frame_done = 1'b0;
        rd_frame_req  = 1'b0;
        $display("step done=%0d req=%0d en=%0d -> W=%0d R=%0d wb=%0d rb=%0d new=%0d rdy=%0d drop=%0d rep=%0d",
                 done, req, enable, wr_slot, rd_slot, wr_base, rd_base,
                 rd_frame_new, stream_ready, dropped_cnt, repeat_cnt);
    endtask

    task automatic check_slots(input string tag, input int w, input int r);
        check({tag, "_wr_slot"}, 32'(wr_slot), 32'(w));
        check({tag, "_rd_slot"}, 32'(rd_slot), 32'(r));
        check({tag, "_wr_base"}, wr_base, 32'(w * 3840));
        check({tag, "_rd_base"}, rd_base, 32'(r * 3840));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        nrst          = 1'b0;
        enable        = 1'b0;
        wr_frame_done = 1'b0;
        rd_frame_req  = 1'b0;

        // Reset state
        repeat (2) @(posedge rgb_clk);
        #1;
        check_slots("reset", 0, 2);
        check("reset_ready", 32'(stream_ready), 32'd0);
        check("reset_new", 32'(rd_frame_new), 32'd0);
        check("reset_drop", 32'(dropped_cnt), 32'd0);
        check("reset_rep", 32'(repeat_cnt), 32'd0);

        // Enable -> FILL
        nrst   = 1'b1;
        enable = 1'b1;
        step(1'b0, 1'b0);
        check_slots("fill", 0, 2);
        check("fill_ready", 32'(stream_ready), 32'd0);

        // Request in FILL is ignored
        step(1'b0, 1'b1);
        check("fill_req_new", 32'(rd_frame_new), 32'd0);
        check("fill_req_rslot", 32'(rd_slot), 32'd2);
        check("fill_req_rep", 32'(repeat_cnt), 32'd0);

        // First done -> STREAM, W=1 P=0 R=2 fresh
        step(1'b1, 1'b0);
        check_slots("first_done", 1, 2);
        check("first_done_ready", 32'(stream_ready), 32'd1);
        check("first_done_new", 32'(rd_frame_new), 32'd0);

        // Fresh request -> R=0 P=2
        step(1'b0, 1'b1);
        check_slots("fresh_req", 1, 0);
        check("fresh_req_new", 32'(rd_frame_new), 32'd1);

        step(1'b0, 1'b0);
        check("new_pulse_end", 32'(rd_frame_new), 32'd0);

        // Stale request -> repeat
        step(1'b0, 1'b1);
        check("stale_new", 32'(rd_frame_new), 32'd0);
        check("stale_rslot", 32'(rd_slot), 32'd0);
        check("stale_rep", 32'(repeat_cnt), cnt(1));

        // Two dones without read: W=2 P=1, then W=1 P=2 with a drop
        step(1'b1, 1'b0);
        check_slots("done_a", 2, 0);
        check("done_a_drop", 32'(dropped_cnt), cnt(0));
        step(1'b1, 1'b0);
        check_slots("done_b", 1, 0);
        check("done_b_drop", 32'(dropped_cnt), cnt(1));

        // Read: R=2 P=0; then two dones to reach W=1 P=0 R=2 fresh
        step(1'b0, 1'b1);
        check_slots("read2", 1, 2);
        check("read2_new", 32'(rd_frame_new), 32'd1);
        step(1'b1, 1'b0);
        check_slots("done_c", 0, 2);
        check("done_c_drop", 32'(dropped_cnt), cnt(1));
        step(1'b1, 1'b0);
        check_slots("done_d", 1, 2);
        check("done_d_drop", 32'(dropped_cnt), cnt(2));

        // Simultaneous done + request: W=0 R=1 P=2, drop
        step(1'b1, 1'b1);
        check_slots("both", 0, 1);
        check("both_new", 32'(rd_frame_new), 32'd1);
        check("both_drop", 32'(dropped_cnt), cnt(3));

        // P=2 is not fresh now -> repeat
        step(1'b0, 1'b1);
        check("after_both_new", 32'(rd_frame_new), 32'd0);
        check("after_both_rep", 32'(repeat_cnt), cnt(2));

        // Request held two cycles counts twice
        rd_frame_req = 1'b1;
        @(posedge rgb_clk);
        #1;
        check("held_1_rep", 32'(repeat_cnt), cnt(3));
        @(posedge rgb_clk);
        #1;
        check("held_2_rep", 32'(repeat_cnt), cnt(4));
        rd_frame_req = 1'b0;
        check_slots("held", 0, 1);

        // Disable: slots back to reset, counters kept
        enable = 1'b0;
        step(1'b0, 1'b0);
        check_slots("disable", 0, 2);
        check("disable_ready", 32'(stream_ready), 32'd0);
        check("disable_drop", 32'(dropped_cnt), cnt(3));
        check("disable_rep", 32'(repeat_cnt), cnt(4));

        // Pulses ignored while disabled
        step(1'b1, 1'b1);
        check_slots("idle_pulses", 0, 2);
        check("idle_new", 32'(rd_frame_new), 32'd0);
        check("idle_rep", 32'(repeat_cnt), cnt(4));

        // Re-enable, done+request in FILL: done taken, request ignored
        enable = 1'b1;
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        check_slots("fill_both", 1, 2);
        check("fill_both_new", 32'(rd_frame_new), 32'd0);
        check("fill_both_ready", 32'(stream_ready), 32'd1);
        check("fill_both_rep", 32'(repeat_cnt), cnt(4));
        check("fill_both_drop", 32'(dropped_cnt), cnt(3));

        // Asynchronous reset mid-cycle
        #2;
        nrst = 1'b0;
        #1;
        check_slots("async_rst", 0, 2);
        check("async_rst_ready", 32'(stream_ready), 32'd0);
        check("async_rst_drop", 32'(dropped_cnt), 32'd0);
        check("async_rst_rep", 32'(repeat_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
